// File: rtl/x_pkg.sv
// Shared constants and the unit-element code type for the thermometer/DWA path.
package x_pkg;
  localparam int P_UNITS = 64;
  localparam int P_PTR_W = 6;
  localparam int P_CNT_W = 7;

  typedef logic [P_UNITS-1:0] x_code_t;
endpackage

// File: rtl/x_popcount.sv
// Combinational popcount built as a balanced adder tree; p_units must be a power of two.
module x_popcount
  import x_pkg::*;
#(
  parameter int p_units = P_UNITS
) (
  input  logic [p_units-1:0]         i_bits,
  output logic [$clog2(p_units):0]   o_count
);
  localparam int LV = $clog2(p_units);
  localparam int CW = LV + 1;

  // Level gl holds p_units>>gl partial sums; level LV is the single total.
  for (genvar gl = 0; gl <= LV; gl++) begin : g_lvl
    logic [CW-1:0] w_sum [0:(p_units>>gl)-1];
    if (gl == 0) begin : g_leaf
      for (genvar gi = 0; gi < p_units; gi++) begin : g_bit
        assign w_sum[gi] = CW'(i_bits[gi]);
      end
    end else begin : g_node
      for (genvar gi = 0; gi < (p_units >> gl); gi++) begin : g_add
        assign w_sum[gi] = g_lvl[gl-1].w_sum[2*gi] + g_lvl[gl-1].w_sum[2*gi+1];
      end
    end
  end

  assign o_count = g_lvl[LV].w_sum[0];
endmodule

// File: rtl/x_dwa.sv
// DWA element rotator: every p_div cycles, registers the thermometer code rotated
// left by a running pointer that advances by the number of active elements.
module x_dwa
  import x_pkg::*;
#(
  parameter int p_units = P_UNITS,
  parameter int p_div   = 256
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic [p_units-1:0]          i_therm,
  input  logic                        i_en,
  output logic [p_units-1:0]          o_code,
  output logic [$clog2(p_units)-1:0]  o_ptr,
  output logic                        o_tick
);
  localparam int PTR_W = $clog2(p_units);
  localparam int CNT_W = (p_div > 1) ? $clog2(p_div) : 1;

  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [p_units-1:0] r_code;
  logic               r_tick;

  logic               w_upd;
  logic [PTR_W:0]     w_n;
  logic [PTR_W-1:0]   w_ptr_adv;
  logic [p_units-1:0] w_rot;

  assign w_upd = (r_cnt == CNT_W'(p_div - 1));

  x_popcount #(.p_units(p_units)) u_popcount (
    .i_bits  (i_therm),
    .o_count (w_n)
  );

  // A full-scale count is a whole turn, so the pointer stays put.
  assign w_ptr_adv = w_n[PTR_W] ? r_ptr : (r_ptr + w_n[PTR_W-1:0]);

  // Log-depth barrel rotator: stage gs rotates left by 2**gs when r_ptr[gs] is set.
  for (genvar gs = 0; gs < PTR_W; gs++) begin : g_rot
    localparam int SH = 1 << gs;
    logic [p_units-1:0] w_in;
    logic [p_units-1:0] w_out;
    if (gs == 0) begin : g_first
      assign w_in = i_therm;
    end else begin : g_next
      assign w_in = g_rot[gs-1].w_out;
    end
    assign w_out = r_ptr[gs] ? {w_in[p_units-1-SH:0], w_in[p_units-1:p_units-SH]} : w_in;
  end

  assign w_rot = g_rot[PTR_W-1].w_out;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_code <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_upd;
      if (w_upd) begin
        r_cnt <= '0;
        if (i_en) begin
          r_code <= w_rot;
          r_ptr  <= w_ptr_adv;
        end else begin
          r_code <= i_therm;
          r_ptr  <= '0;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_code = r_code;
  assign o_ptr  = r_ptr;
  assign o_tick = r_tick;
endmodule

// File: tb/tb_x_dwa.sv
// Bench for x_dwa with a short update period: cycle-by-cycle model comparison
// plus directed literal checks of divider, bypass, rotation, wrap and reset.
module tb_x_dwa;
  localparam int N     = 64;
  localparam int P_DIV = 4;

  logic          clk   = 1'b0;
  logic          nrst  = 1'b0;
  logic          en    = 1'b0;
  logic [N-1:0]  therm = '0;
  logic [N-1:0]  o_code;
  logic [5:0]    o_ptr;
  logic          o_tick;

  int nchk = 0;
  int nbad = 0;

  x_dwa #(.p_units(N), .p_div(P_DIV)) dut (
    .i_clk   (clk),
    .i_nrst  (nrst),
    .i_therm (therm),
    .i_en    (en),
    .o_code  (o_code),
    .o_ptr   (o_ptr),
    .o_tick  (o_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int p);
    logic [2*N-1:0] d;
    d = {x, x} << p;
    return d[2*N-1:N];
  endfunction

  // Model: ticks fall every P_DIV cycles after release; pointer is a running sum mod N.
  int         m_cyc  = 0;
  logic [N-1:0] m_code = '0;
  logic [5:0] m_ptr  = '0;
  logic       m_tick = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_cyc  <= 0;
      m_code <= '0;
      m_ptr  <= '0;
      m_tick <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc % P_DIV) == P_DIV - 1) begin
        m_tick <= 1'b1;
        if (en) begin
          m_code <= rotl(therm, int'(m_ptr));
          m_ptr  <= 6'((int'(m_ptr) + $countones(therm)) % N);
        end else begin
          m_code <= therm;
          m_ptr  <= '0;
        end
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    nchk++;
    if (o_code !== m_code || o_ptr !== m_ptr || o_tick !== m_tick) begin
      nbad++;
      $display("FAIL model t=%0t code=%h want=%h ptr=%0d want=%0d tick=%b want=%b",
               $time, o_code, m_code, o_ptr, m_ptr, o_tick, m_tick);
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_tick(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * P_DIV && !seen; i++) begin
      @(negedge clk);
      if (o_tick) seen = 1'b1;
    end
    nchk++;
    if (!seen) begin
      nbad++;
      $display("FAIL %s_timeout act=no_tick exp=tick", nm);
    end
    $display("tick %s code=%h ptr=%0d", nm, o_code, o_ptr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rot_code [3];
    int           rot_ptr  [3];
    rot_code = '{64'hFF, 64'hFF00, 64'hFF0000};
    rot_ptr  = '{8, 16, 24};

    repeat (3) @(negedge clk);
    chk("rst_code", o_code, '0);
    chk("rst_ptr",  64'(o_ptr), 64'd0);
    chk("rst_tick", 64'(o_tick), 64'd0);

    // Divider and bypass
    therm = 64'hFF;
    en    = 1'b0;
    nrst  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("div_tick%0d", k), 64'(o_tick), 64'((k % 4) == 0));
      if ((k % 4) == 0) begin
        $display("tick bypass%0d code=%h ptr=%0d", k, o_code, o_ptr);
        chk($sformatf("bypass_code%0d", k), o_code, 64'hFF);
        chk($sformatf("bypass_ptr%0d", k), 64'(o_ptr), 64'd0);
      end
    end

    // Rotation
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick($sformatf("rot%0d", i));
      chk($sformatf("rot_code%0d", i), o_code, rot_code[i]);
      chk($sformatf("rot_ptr%0d", i), 64'(o_ptr), 64'(rot_ptr[i]));
    end

    // Wrap: clear, preload 60 with four 15-element updates, then rotate 0xFF
    en = 1'b0;
    wait_tick("clear");
    chk("clear_ptr", 64'(o_ptr), 64'd0);
    en = 1'b1;
    therm = 64'h7FFF;
    for (int i = 0; i < 4; i++) wait_tick($sformatf("preload%0d", i));
    chk("preload_ptr", 64'(o_ptr), 64'd60);
    therm = 64'hFF;
    wait_tick("wrap");
    chk("wrap_code", o_code, 64'hF00000000000000F);
    chk("wrap_ptr", 64'(o_ptr), 64'd4);

    // Extremes at ptr=5
    therm = 64'h1;
    wait_tick("step");
    chk("step_code", o_code, 64'h10);
    chk("step_ptr", 64'(o_ptr), 64'd5);
    therm = '0;
    wait_tick("zeros");
    chk("zeros_code", o_code, '0);
    chk("zeros_ptr", 64'(o_ptr), 64'd5);
    therm = '1;
    wait_tick("ones");
    chk("ones_code", o_code, '1);
    chk("ones_ptr", 64'(o_ptr), 64'd5);
    en = 1'b0;
    wait_tick("disable");
    chk("disable_ptr", 64'(o_ptr), 64'd0);
    chk("disable_code", o_code, '1);

    // Inputs changing between updates must not reach the outputs
    therm = 64'hDEAD;
    @(negedge clk);
    chk("hold_code1", o_code, '1);
    therm = 64'hBEEF;
    @(negedge clk);
    chk("hold_code2", o_code, '1);
    therm = 64'h3;
    wait_tick("sampled");
    chk("sampled_code", o_code, 64'h3);

    // Mid-period asynchronous reset at cnt=2
    en    = 1'b1;
    therm = 64'hF0;
    wait_tick("pre_rst");
    chk("pre_rst_code", o_code, 64'hF0);
    chk("pre_rst_ptr", 64'(o_ptr), 64'd4);
    @(negedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("async_code", o_code, '0);
    chk("async_ptr", 64'(o_ptr), 64'd0);
    chk("async_tick", 64'(o_tick), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 1; k <= P_DIV; k++) begin
      @(negedge clk);
      chk($sformatf("restart_tick%0d", k), 64'(o_tick), 64'(k == P_DIV));
    end
    $display("tick restart code=%h ptr=%0d", o_code, o_ptr);
    chk("restart_code", o_code, 64'hF0);
    chk("restart_ptr", 64'(o_ptr), 64'd4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
